// File: rtl/ham_enc_arbiter.sv
// ham_enc_arbiter: round-robin byte arbiter feeding a shared Hamming(7,4) encoder, low nibble first
module ham_enc_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [7:0]       a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [7:0]       b_data,
  output logic             b_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_code,
  output logic             out_src,
  output logic             out_half,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0, LO = 2'd1, HI = 2'd2;
  logic [1:0] state;
  logic [7:0] hold;
  logic cur_src, last_src, idle, grant_b;
  logic [3:0] nib;
  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction
  // Grant only in IDLE; a tie goes to the requester not served last, readies held low during reset
  always_comb begin
    idle = state == IDLE;
    grant_b = b_valid & (~a_valid | ~last_src);
    a_ready = ~rst & idle & a_valid & ~grant_b;
    b_ready = ~rst & idle & grant_b;
    nib = state == HI ? hold[7:4] : hold[3:0];
    out_code = enc(nib);
    out_valid = ~idle;
    out_half = state == HI;
    out_src = cur_src;
    busy = ~idle;
  end
  // Byte capture, nibble sequencing and completed-byte bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      cur_src <= 1'b0;
      last_src <= 1'b1;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (a_ready | b_ready) begin
          hold <= a_ready ? a_data : b_data;
          cur_src <= b_ready;
          state <= LO;
        end
        LO: if (out_ready) state <= HI;
        HI: if (out_ready) begin
          state <= IDLE;
          byte_cnt <= byte_cnt + CNT_W'(1);
          last_src <= cur_src;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
